// File: rtl/dcache_port_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter
//
// Single-port scheduler in front of the Dcache request port. The load pipeline
// and the store-buffer drain share the port. Only one transaction is ever
// outstanding. Loads normally win arbitration. A waiting store is forced
// through in two cases: it has lost STARVE_MAX consecutive arbitrations, or the
// store buffer is at or above HIGH_WATER. Dbar/Ibar barriers block loads and
// drain stores until the store buffer reports empty.
//
// Ports
//   Clk, Rest                 clock, asynchronous active-high reset
//   Flush                     kills load traffic only
//   LdReq/LdAddr/LdMat        load request; LdAck pulses on capture
//   LdRespValid/LdRespData    load data return
//   SbReq/SbPtr/SbAddr/SbData/SbMat/SbCount/SbEmpty
//                             store-buffer drain request and occupancy
//   SbAck/SbDone/SbDonePtr    store captured / store written
//   BarReq/BarDone            retired barrier waiting / barrier satisfied
//   DcReq*                    Dcache request channel (valid/ready)
//   DcRespValid/DcRespData    Dcache response (one cycle)
//
// Optional build macro: SB_ARB_PERF_EN adds the 32-bit saturating counters
// PerfLdGrant, PerfSbGrant, PerfStarvePromote and PerfBarCycles.
// -----------------------------------------------------------------------------
module dcache_port_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int HIGH_WATER = 5,
  parameter int CNT_W      = 4
) (
  input  logic        Clk,
  input  logic        Rest,
  input  logic        Flush,
  input  logic        LdReq,
  input  logic [31:0] LdAddr,
  input  logic [1:0]  LdMat,
  output logic        LdAck,
  output logic        LdRespValid,
  output logic [31:0] LdRespData,
  input  logic        SbReq,
  input  logic [2:0]  SbPtr,
  input  logic [31:0] SbAddr,
  input  logic [31:0] SbData,
  input  logic [1:0]  SbMat,
  input  logic [2:0]  SbCount,
  input  logic        SbEmpty,
  output logic        SbAck,
  output logic        SbDone,
  output logic [2:0]  SbDonePtr,
  input  logic        BarReq,
  output logic        BarDone,
  output logic        DcReqValid,
  output logic        DcReqWrite,
  output logic [31:0] DcReqAddr,
  output logic [31:0] DcReqData,
  output logic [1:0]  DcReqMat,
  output logic [2:0]  DcReqTag,
  input  logic        DcReqReady,
  input  logic        DcRespValid,
  input  logic [31:0] DcRespData
`ifdef SB_ARB_PERF_EN
  ,
  output logic [31:0] PerfLdGrant,
  output logic [31:0] PerfSbGrant,
  output logic [31:0] PerfStarvePromote,
  output logic [31:0] PerfBarCycles
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LD_REQ    = 3'd1;
  localparam logic [2:0] S_ST_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_BAR_DRAIN = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kill_q, kill_d;
  logic             bar_q, bar_d;
  logic             wr_q, wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       mat_q, mat_d;
  logic [2:0]       tag_q, tag_d;

  logic starved_s, st_win_s, ld_win_s;
  logic grant_ld_s, grant_st_s, ld_resp_s, sb_done_s, bar_done_s;

  // A flushed load still counts as LdReq in the store-win term, so a flush
  // does not by itself hand the port to a store.
  assign starved_s = (cnt_q >= CNT_W'(STARVE_MAX));
  assign st_win_s  = SbReq & (~LdReq | (SbCount >= 3'(HIGH_WATER)) | starved_s);
  assign ld_win_s  = LdReq & ~Flush & ~st_win_s;

  // Next-state, grant and capture logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kill_d     = kill_q;
    bar_d      = bar_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mat_d      = mat_q;
    tag_d      = tag_q;
    grant_ld_s = 1'b0;
    grant_st_s = 1'b0;
    ld_resp_s  = 1'b0;
    sb_done_s  = 1'b0;
    bar_done_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (BarReq) begin
          bar_d   = 1'b1;
          state_d = S_BAR_DRAIN;
        end else if (st_win_s) begin
          grant_st_s = 1'b1;
        end else if (ld_win_s) begin
          grant_ld_s = 1'b1;
          // Count only loads that beat a waiting store; saturate at the limit.
          if (SbReq && !starved_s) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LD_REQ: begin
        bar_d = bar_q | BarReq;
        if (Flush) begin
          // Accepted in the same cycle as the flush: the response will still
          // come back, so absorb it instead of dropping the request.
          if (DcReqReady) begin
            kill_d  = 1'b1;
            state_d = S_WAIT_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (DcReqReady) begin
          state_d = S_WAIT_RESP;
        end else begin
          state_d = S_LD_REQ;
        end
      end
      S_ST_REQ: begin
        bar_d = bar_q | BarReq;
        if (DcReqReady) begin
          state_d = S_WAIT_RESP;
        end else begin
          state_d = S_ST_REQ;
        end
      end
      S_WAIT_RESP: begin
        bar_d = bar_q | BarReq;
        if (DcRespValid) begin
          ld_resp_s = ~wr_q & ~kill_q & ~Flush;
          sb_done_s = wr_q;
          kill_d    = 1'b0;
          state_d   = (bar_q | BarReq) ? S_BAR_DRAIN : S_IDLE;
        end else if (Flush && !wr_q) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end
      S_BAR_DRAIN: begin
        if (SbEmpty) begin
          bar_done_s = 1'b1;
          bar_d      = 1'b0;
          state_d    = S_IDLE;
        end else if (SbReq) begin
          grant_st_s = 1'b1;
        end else begin
          state_d = S_BAR_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (grant_st_s) begin
      state_d = S_ST_REQ;
      cnt_d   = '0;
      wr_d    = 1'b1;
      addr_d  = SbAddr;
      data_d  = SbData;
      mat_d   = SbMat;
      tag_d   = SbPtr;
    end else if (grant_ld_s) begin
      state_d = S_LD_REQ;
      wr_d    = 1'b0;
      addr_d  = LdAddr;
      data_d  = 32'd0;
      mat_d   = LdMat;
      tag_d   = 3'd0;
    end else begin
      addr_d = addr_q;
    end
  end

  // State and captured-request registers
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      bar_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      mat_q   <= 2'd0;
      tag_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      bar_q   <= bar_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mat_q   <= mat_d;
      tag_q   <= tag_d;
    end
  end

  assign LdAck       = grant_ld_s;
  assign SbAck       = grant_st_s;
  assign LdRespValid = ld_resp_s;
  assign LdRespData  = ld_resp_s ? DcRespData : 32'd0;
  assign SbDone      = sb_done_s;
  assign SbDonePtr   = sb_done_s ? tag_q : 3'd0;
  assign BarDone     = bar_done_s;
  assign DcReqValid  = (state_q == S_LD_REQ) | (state_q == S_ST_REQ);
  assign DcReqWrite  = wr_q;
  assign DcReqAddr   = addr_q;
  assign DcReqData   = data_q;
  assign DcReqMat    = mat_q;
  assign DcReqTag    = tag_q;

`ifdef SB_ARB_PERF_EN
  logic [31:0] perf_ld_q, perf_ld_d;
  logic [31:0] perf_sb_q, perf_sb_d;
  logic [31:0] perf_starve_q, perf_starve_d;
  logic [31:0] perf_bar_q, perf_bar_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
  endfunction

  // Saturating event counters
  always_comb begin
    perf_ld_d     = sat_inc(perf_ld_q, grant_ld_s);
    perf_sb_d     = sat_inc(perf_sb_q, grant_st_s);
    perf_starve_d = sat_inc(perf_starve_q, grant_st_s & (state_q == S_IDLE) & starved_s);
    perf_bar_d    = sat_inc(perf_bar_q, state_q == S_BAR_DRAIN);
  end

  // Counter registers
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      perf_ld_q     <= 32'd0;
      perf_sb_q     <= 32'd0;
      perf_starve_q <= 32'd0;
      perf_bar_q    <= 32'd0;
    end else begin
      perf_ld_q     <= perf_ld_d;
      perf_sb_q     <= perf_sb_d;
      perf_starve_q <= perf_starve_d;
      perf_bar_q    <= perf_bar_d;
    end
  end

  assign PerfLdGrant       = perf_ld_q;
  assign PerfSbGrant       = perf_sb_q;
  assign PerfStarvePromote = perf_starve_q;
  assign PerfBarCycles     = perf_bar_q;
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dcache_port_arbiter: an arbitration-decision table,
// hand-written multi-cycle sequences, and a randomized run against a
// transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_dcache_port_arbiter;

  logic        Clk, Rest, Flush;
  logic        LdReq;
  logic [31:0] LdAddr;
  logic [1:0]  LdMat;
  logic        LdAck, LdRespValid;
  logic [31:0] LdRespData;
  logic        SbReq;
  logic [2:0]  SbPtr;
  logic [31:0] SbAddr, SbData;
  logic [1:0]  SbMat;
  logic [2:0]  SbCount;
  logic        SbEmpty, SbAck, SbDone;
  logic [2:0]  SbDonePtr;
  logic        BarReq, BarDone;
  logic        DcReqValid, DcReqWrite;
  logic [31:0] DcReqAddr, DcReqData;
  logic [1:0]  DcReqMat;
  logic [2:0]  DcReqTag;
  logic        DcReqReady, DcRespValid;
  logic [31:0] DcRespData;

  int n_chk = 0;
  int n_err = 0;

  dcache_port_arbiter dut (
    .Clk(Clk), .Rest(Rest), .Flush(Flush),
    .LdReq(LdReq), .LdAddr(LdAddr), .LdMat(LdMat), .LdAck(LdAck),
    .LdRespValid(LdRespValid), .LdRespData(LdRespData),
    .SbReq(SbReq), .SbPtr(SbPtr), .SbAddr(SbAddr), .SbData(SbData),
    .SbMat(SbMat), .SbCount(SbCount), .SbEmpty(SbEmpty), .SbAck(SbAck),
    .SbDone(SbDone), .SbDonePtr(SbDonePtr), .BarReq(BarReq), .BarDone(BarDone),
    .DcReqValid(DcReqValid), .DcReqWrite(DcReqWrite), .DcReqAddr(DcReqAddr),
    .DcReqData(DcReqData), .DcReqMat(DcReqMat), .DcReqTag(DcReqTag),
    .DcReqReady(DcReqReady), .DcRespValid(DcRespValid), .DcRespData(DcRespData)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Flush = 1'b0; LdReq = 1'b0; LdAddr = 32'd0; LdMat = 2'd0;
    SbReq = 1'b0; SbPtr = 3'd0; SbAddr = 32'd0; SbData = 32'd0; SbMat = 2'd0;
    SbCount = 3'd0; SbEmpty = 1'b0; BarReq = 1'b0;
    DcReqReady = 1'b0; DcRespValid = 1'b0; DcRespData = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Rest = 1'b1;
    tick();
    tick();
    Rest = 1'b0;
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_kind;      // 0 no transaction, 1 load, 2 store
  bit          m_issued;    // request accepted by the cache, awaiting data
  bit          m_drain;     // barrier in progress
  bit          m_bar_pend;  // barrier arrived while a transaction was open
  bit          m_killed;
  int          m_losses;    // loads granted over a waiting store since last store grant
  logic [31:0] m_addr, m_data;
  logic [2:0]  m_tag;

  task automatic model_init();
    m_kind = 0; m_issued = 0; m_drain = 0; m_bar_pend = 0; m_killed = 0;
    m_losses = 0; m_addr = 32'd0; m_data = 32'd0; m_tag = 3'd0;
  endtask

  task automatic model_check();
    bit e_v, e_la, e_sa, e_lr, e_sd, e_bd, st, ld;
    logic [2:0] done_tag;
    e_v = (m_kind != 0) && !m_issued;
    e_la = 0; e_sa = 0; e_lr = 0; e_sd = 0; e_bd = 0;
    done_tag = m_tag;
    if (e_v) begin
      chk("rnd_write", DcReqWrite, (m_kind == 2) ? 32'd1 : 32'd0);
      chk("rnd_addr", DcReqAddr, m_addr);
      chk("rnd_data", DcReqData, m_data);
      chk("rnd_tag", DcReqTag, m_tag);
    end
    if (m_kind == 0) begin
      if (!m_drain) begin
        if (BarReq) begin
          m_drain = 1;
        end else begin
          st = SbReq && (!LdReq || SbCount >= 3'd5 || m_losses >= 8);
          ld = LdReq && !Flush && !st;
          if (st) e_sa = 1;
          if (ld) begin
            e_la = 1;
            if (SbReq && m_losses < 8) m_losses++;
            m_kind = 1; m_addr = LdAddr; m_data = 32'd0; m_tag = 3'd0;
          end
        end
      end else if (SbEmpty) begin
        e_bd = 1;
        m_drain = 0;
      end else if (SbReq) begin
        e_sa = 1;
      end
      if (e_sa) begin
        m_kind = 2; m_addr = SbAddr; m_data = SbData; m_tag = SbPtr; m_losses = 0;
      end
    end else if (!m_issued) begin
      if (BarReq) m_bar_pend = 1;
      if (m_kind == 1 && Flush) begin
        if (DcReqReady) begin m_issued = 1; m_killed = 1; end
        else m_kind = 0;
      end else if (DcReqReady) begin
        m_issued = 1;
      end
    end else begin
      if (BarReq) m_bar_pend = 1;
      if (DcRespValid) begin
        e_lr = (m_kind == 1) && !m_killed && !Flush;
        e_sd = (m_kind == 2);
        m_kind = 0; m_issued = 0; m_killed = 0;
        if (m_bar_pend) m_drain = 1;
        m_bar_pend = 0;
      end else if (m_kind == 1 && Flush) begin
        m_killed = 1;
      end
    end
    chk("rnd_dcvalid", DcReqValid, e_v);
    chk("rnd_ldack", LdAck, e_la);
    chk("rnd_sback", SbAck, e_sa);
    chk("rnd_ldresp", LdRespValid, e_lr);
    chk("rnd_sbdone", SbDone, e_sd);
    chk("rnd_bardone", BarDone, e_bd);
    if (e_lr) chk("rnd_lddata", LdRespData, DcRespData);
    if (e_sd) chk("rnd_doneptr", SbDonePtr, done_tag);
  endtask

  // ---------------- arbitration decision table ----------------
  typedef struct {
    string      name;
    logic       ld, fl, sb;
    logic [2:0] cnt;
    logic       bar;
    logic       e_la, e_sa, e_v, e_w;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int arb, ld_early, ld_after, sb_acks, sb_dones, bds, pend, done, first_sb, second_sb;
    bit seen_bd, both;
    int sb_at[$];

    vecs[0] = '{"load_only",    1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"store_only",   1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{"both_cnt2",    1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"both_cnt4",    1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"both_hw5",     1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{"both_hw7",     1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{"load_flushed", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"bar_with_ld",  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{"idle",         1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    Rest = 1'b0;
    do_reset();

    // Reset state
    #2;
    chk("rst_ldack", LdAck, 32'd0);
    chk("rst_sback", SbAck, 32'd0);
    chk("rst_dcvalid", DcReqValid, 32'd0);
    chk("rst_dcwrite", DcReqWrite, 32'd0);
    chk("rst_dcaddr", DcReqAddr, 32'd0);
    chk("rst_dctag", DcReqTag, 32'd0);
    chk("rst_ldresp", LdRespValid, 32'd0);
    chk("rst_sbdone", SbDone, 32'd0);
    chk("rst_bardone", BarDone, 32'd0);

    foreach (vecs[i]) begin
      do_reset();
      LdReq = vecs[i].ld; Flush = vecs[i].fl; SbReq = vecs[i].sb;
      SbCount = vecs[i].cnt; BarReq = vecs[i].bar; SbPtr = 3'd6;
      LdAddr = 32'h0000_2000; SbAddr = 32'h0000_3000;
      #2;
      chk({vecs[i].name, "_ldack"}, LdAck, vecs[i].e_la);
      chk({vecs[i].name, "_sback"}, SbAck, vecs[i].e_sa);
      tick();
      clear_inputs();
      #2;
      chk({vecs[i].name, "_valid"}, DcReqValid, vecs[i].e_v);
      if (vecs[i].e_v) chk({vecs[i].name, "_write"}, DcReqWrite, vecs[i].e_w);
      tick();
    end

    // Load only: ack at N, request at N+1, accept at N+2, data at N+4
    do_reset();
    LdReq = 1'b1; LdAddr = 32'h0000_1000;
    #2; chk("ld_ack_N", LdAck, 32'd1);
    tick(); LdReq = 1'b0;
    #2; chk("ld_valid_N1", DcReqValid, 32'd1);
    chk("ld_write_N1", DcReqWrite, 32'd0);
    chk("ld_addr_N1", DcReqAddr, 32'h0000_1000);
    chk("ld_data_N1", DcReqData, 32'd0);
    tick(); DcReqReady = 1'b1;
    #2; chk("ld_valid_N2", DcReqValid, 32'd1);
    tick(); DcReqReady = 1'b0;
    #2; chk("ld_valid_N3", DcReqValid, 32'd0);
    chk("ld_noresp_N3", LdRespValid, 32'd0);
    tick(); DcRespValid = 1'b1; DcRespData = 32'hDEAD_BEEF;
    #2; chk("ld_resp_N4", LdRespValid, 32'd1);
    chk("ld_data_N4", LdRespData, 32'hDEAD_BEEF);
    tick(); clear_inputs();

    // Starvation: single-cycle cache, both requesters held
    do_reset();
    LdReq = 1'b1; SbReq = 1'b1; SbCount = 3'd2; SbPtr = 3'd4;
    DcReqReady = 1'b1; DcRespValid = 1'b1;
    arb = 0; both = 0;
    for (int c = 0; c < 80; c++) begin
      #2;
      if (LdAck || SbAck) arb++;
      if (SbAck) sb_at.push_back(arb);
      if (LdAck && SbAck) both = 1;
      tick();
    end
    clear_inputs();
    first_sb  = (sb_at.size() > 0) ? sb_at[0] : 0;
    second_sb = (sb_at.size() > 1) ? sb_at[1] : 0;
    chk("starve_first_store_arb", first_sb, 32'd9);
    chk("starve_second_store_arb", second_sb, 32'd18);
    chk("starve_no_double_ack", both, 32'd0);

    // High water: store wins over a simultaneous load
    do_reset();
    LdReq = 1'b1; SbReq = 1'b1; SbCount = 3'd5; SbPtr = 3'd3;
    SbAddr = 32'h0000_4440; SbData = 32'h1234_5678;
    #2; chk("hw_sback", SbAck, 32'd1);
    chk("hw_ldack", LdAck, 32'd0);
    tick(); LdReq = 1'b0; SbReq = 1'b0;
    #2; chk("hw_write", DcReqWrite, 32'd1);
    chk("hw_tag", DcReqTag, 32'd3);
    chk("hw_data", DcReqData, 32'h1234_5678);
    DcReqReady = 1'b1;
    tick(); DcReqReady = 1'b0;
    tick(); DcRespValid = 1'b1;
    #2; chk("hw_sbdone", SbDone, 32'd1);
    chk("hw_doneptr", SbDonePtr, 32'd3);
    tick(); clear_inputs();

    // Barrier with two stores pending and a held load
    do_reset();
    pend = 2; done = 0; seen_bd = 0;
    ld_early = 0; ld_after = 0; sb_acks = 0; sb_dones = 0; bds = 0;
    LdReq = 1'b1; DcReqReady = 1'b1; DcRespValid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      SbReq = (pend > 0); SbPtr = 3'(pend); SbCount = 3'(2 - done);
      SbEmpty = (done == 2); BarReq = !seen_bd;
      #2;
      if (LdAck) begin
        if (seen_bd) ld_after++;
        else ld_early++;
      end
      if (SbAck) begin sb_acks++; pend--; end
      if (SbDone) begin sb_dones++; done++; end
      if (BarDone) begin bds++; seen_bd = 1; end
      tick();
    end
    clear_inputs();
    chk("bar_ldack_blocked", ld_early, 32'd0);
    chk("bar_store_acks", sb_acks, 32'd2);
    chk("bar_store_dones", sb_dones, 32'd2);
    chk("bar_done_once", bds, 32'd1);
    chk("bar_load_after", (ld_after > 0), 32'd1);

    // Flush kill in WAIT_RESP, then a store completes normally
    do_reset();
    LdReq = 1'b1; LdAddr = 32'h0000_5000;
    tick(); LdReq = 1'b0; DcReqReady = 1'b1;
    tick(); DcReqReady = 1'b0; Flush = 1'b1;
    #2; chk("fk_noresp_flush", LdRespValid, 32'd0);
    tick(); Flush = 1'b0; DcRespValid = 1'b1; DcRespData = 32'hCAFE_0001;
    #2; chk("fk_resp_absorbed", LdRespValid, 32'd0);
    tick(); DcRespValid = 1'b0; SbReq = 1'b1; SbCount = 3'd1; SbPtr = 3'd5;
    #2; chk("fk_idle_sback", SbAck, 32'd1);
    tick(); SbReq = 1'b0;
    #2; chk("fk_st_write", DcReqWrite, 32'd1);
    DcReqReady = 1'b1;
    tick(); DcReqReady = 1'b0; DcRespValid = 1'b1;
    #2; chk("fk_sbdone", SbDone, 32'd1);
    chk("fk_doneptr", SbDonePtr, 32'd5);
    tick(); clear_inputs();

    // Reset in ST_REQ abandons the store
    do_reset();
    SbReq = 1'b1; SbPtr = 3'd2; SbCount = 3'd1;
    tick(); SbReq = 1'b0;
    #2; chk("rm_valid_before", DcReqValid, 32'd1);
    Rest = 1'b1;
    #1; chk("rm_valid_async", DcReqValid, 32'd0);
    DcReqReady = 1'b1; DcRespValid = 1'b1;
    tick(); Rest = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2; chk("rm_no_sbdone", SbDone, 32'd0);
      tick();
    end
    LdReq = 1'b1;
    #2; chk("rm_idle_ldack", LdAck, 32'd1);
    tick(); clear_inputs();

    // Randomized run against the reference model
    do_reset();
    model_init();
    for (int c = 0; c < 800; c++) begin
      LdReq = ($urandom_range(0, 3) != 0);
      LdAddr = $urandom();
      LdMat = 2'($urandom_range(0, 3));
      Flush = ($urandom_range(0, 9) == 0);
      SbReq = ($urandom_range(0, 1) == 1);
      SbPtr = 3'($urandom_range(1, 7));
      SbAddr = $urandom();
      SbData = $urandom();
      SbMat = 2'($urandom_range(0, 3));
      SbCount = 3'($urandom_range(0, 7));
      SbEmpty = ($urandom_range(0, 2) == 0);
      BarReq = ($urandom_range(0, 24) == 0);
      DcReqReady = ($urandom_range(0, 1) == 1);
      DcRespValid = ($urandom_range(0, 2) == 0);
      DcRespData = $urandom();
      #2;
      model_check();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Single-port scheduler in front of the Dcache request port, shared by the load pipeline (AGU load) and the store-buffer drain.
- Decides which requester owns the port each transaction and keeps one transaction outstanding at a time.
- Enforces load priority with store-starvation and high-water promotion.
- Sequences Dbar/Ibar barriers: loads are blocked and stores drained until the store buffer reports empty.

Parameters:
- STARVE_MAX, 8, consecutive load-won cycles with a pending store before the store is forced to win.
- HIGH_WATER, 5, store-buffer occupancy (1..7) at or above which the store wins outright.
- CNT_W, 4, starvation counter width; must hold STARVE_MAX.

Ports:
- Clk  in  1  clock
- Rest  in  1  asynchronous reset, active-high
- Flush  in  1  pipeline flush; kills load traffic only
- LdReq  in  1  load request valid
- LdAddr  in  32  load physical address
- LdMat  in  2  load memory access type
- LdAck  out  1  one-cycle pulse: load captured; requester may drop LdReq
- LdRespValid  out  1  load data valid
- LdRespData  out  32  load data
- SbReq  in  1  store-buffer entry ready to drain
- SbPtr  in  3  store-buffer entry index (1..7)
- SbAddr  in  32  store physical address
- SbData  in  32  store data, already byte-masked
- SbMat  in  2  store memory access type
- SbCount  in  3  valid store-buffer entries
- SbEmpty  in  1  store buffer empty
- SbAck  out  1  one-cycle pulse: store captured
- SbDone  out  1  one-cycle pulse: store written
- SbDonePtr  out  3  entry index for SbDone
- BarReq  in  1  retired Dbar/Ibar waiting
- BarDone  out  1  one-cycle pulse: barrier satisfied
- DcReqValid  out  1  Dcache request valid
- DcReqWrite  out  1  1 = store, 0 = load
- DcReqAddr  out  32  request address
- DcReqData  out  32  store data (0 for loads)
- DcReqMat  out  2  memory access type
- DcReqTag  out  3  SbPtr for stores, 0 for loads
- DcReqReady  in  1  Dcache accepts the request
- DcRespValid  in  1  Dcache response; one cycle
- DcRespData  in  32  load data

Behaviour:
- Reset: all outputs 0, state IDLE, starvation counter 0, kill flag 0, captured registers 0.
- States: IDLE, LD_REQ, ST_REQ, WAIT_RESP, BAR_DRAIN.
- IDLE, BarReq=1: go to BAR_DRAIN; a load arriving in the same cycle is not captured.
- IDLE, no barrier, store wins: condition is SbReq & (~LdReq | SbCount>=HIGH_WATER | cnt>=STARVE_MAX).
  - Capture Sb* fields, pulse SbAck, clear cnt, go to ST_REQ.
- IDLE, load wins: condition is LdReq & ~Flush and store does not win.
  - Capture Ld* fields, pulse LdAck, go to LD_REQ.
  - cnt increments, saturating at STARVE_MAX, when SbReq was also 1.
- IDLE, Flush=1 with LdReq: the load is ignored.
- Latency: request sampled in cycle N gives Ack in cycle N and DcReqValid in N+1.
- LD_REQ / ST_REQ: DcReqValid=1 with captured fields, held stable until DcReqReady; then go to WAIT_RESP.
  - Flush in LD_REQ before accept: drop DcReqValid next cycle, return to IDLE, no response.
  - Flush never affects ST_REQ.
- WAIT_RESP: on DcRespValid, return to IDLE (or BAR_DRAIN if the barrier flag is set).
  - Load: LdRespValid=1 and LdRespData=DcRespData in the same cycle, unless the kill flag is set.
  - Store: SbDone=1 and SbDonePtr=captured tag.
  - Flush during a load in WAIT_RESP sets the kill flag: the response is absorbed and the flag cleared.
  - A request is never issued before the response returns.
- BarReq while busy: latch the barrier flag and enter BAR_DRAIN after the response.
- BAR_DRAIN:
  - Loads never captured, LdAck=0.
  - Stores granted unconditionally via ST_REQ/WAIT_RESP, returning to BAR_DRAIN.
  - When SbEmpty=1 and no transaction is outstanding: pulse BarDone, clear the flag, go to IDLE.
  - SbEmpty already 1 on entry: BarDone on the next cycle.
  - Flush does not cancel a barrier; barriers are retired.
- DcReqData is 0 and DcReqWrite is 0 for loads.
- DcRespValid outside WAIT_RESP is ignored.
- Reset is asynchronous at any state: the outstanding transaction is abandoned and no Done/Resp is emitted.

Optional Feature:
- SB_ARB_PERF_EN defined adds outputs PerfLdGrant, PerfSbGrant, PerfStarvePromote, PerfBarCycles, each 32-bit.
  - Saturating counters, reset to 0.
  - Count load grants, store grants, store grants caused by cnt>=STARVE_MAX, and cycles spent in BAR_DRAIN.
- Undefined: no such ports and no counter logic.

Test Plan:
- Load only: LdReq, LdAddr=0x1000.
  - Required: LdAck cycle N; DcReqValid, DcReqWrite=0 at N+1.
  - With DcReqReady at N+2 and DcRespValid at N+4, DcRespData=0xDEADBEEF: LdRespValid at N+4 with 0xDEADBEEF.
- Starvation: SbReq held with SbCount=2, LdReq held continuously, single-cycle Dcache.
  - Required: store granted on the 9th arbitration (cnt reaches 8); SbAck pulses and cnt clears.
- High water: LdReq and SbReq with SbCount=5 in the same cycle.
  - Required: SbAck, DcReqWrite=1, DcReqTag=SbPtr=3; later SbDone with SbDonePtr=3.
- Barrier: BarReq with 2 stores pending while LdReq is held.
  - Required: only 2 store transactions and LdAck stays 0.
  - SbEmpty rises, then BarDone pulses exactly once; afterwards the load is granted.
- Flush kill: Flush asserted in WAIT_RESP for a load.
  - Required: DcRespValid yields no LdRespValid; arbiter returns to IDLE.
  - A later store still completes normally.
- Reset mid-transaction: Rest pulsed in ST_REQ.
  - Required: DcReqValid=0 immediately, no SbDone, state IDLE.
